// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer: control characters,
// FSM state encoding and the default 640x480 / 8x8-glyph screen geometry.
package text_console_writer_pkg;

  localparam int DEFAULT_COLS   = 80;
  localparam int DEFAULT_ROWS   = 60;
  localparam int DEFAULT_ADDR_W = 13;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream input (valid/ready) plus the character RAM write port.
// The writer is the slave of the byte stream and drives the RAM port.
interface text_console_writer_if #(
  parameter int ADDR_W = 13
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/text_console_writer.sv
// Writer side of the character-cell text display. Accepts a byte stream,
// keeps a cursor, writes glyph codes into the character RAM and handles
// CR / LF / BS / FF. The screen wraps to row 0 instead of scrolling, and
// every newline blanks the row it lands on.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int COLS   = DEFAULT_COLS,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  text_console_writer_if.slave  bus,
  output logic [6:0]            cur_col,
  output logic [5:0]            cur_row,
  output logic                  busy
);

  if (ROWS * COLS > 2 ** ADDR_W) begin : g_geometry_check
    $error("text_console_writer: ROWS*COLS does not fit in ADDR_W");
  end

  // Sized copies of the geometry so comparisons stay width-exact.
  localparam logic [6:0]      COL_LAST = 7'(COLS - 1);
  localparam logic [5:0]      ROW_LAST = 6'(ROWS - 1);
  localparam logic [7:0]      LINE_END = 8'(COLS);
  localparam logic [ADDR_W:0] CLR_END  = (ADDR_W + 1)'(ROWS * COLS);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

  state_t            state, state_nxt;
  logic [6:0]        col, col_nxt;
  logic [5:0]        row, row_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;   // row * COLS, kept incrementally
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;     // full-screen clear address, one bit wider for the end mark
  logic [7:0]        line_cnt, line_cnt_nxt;   // cell index inside the row being blanked

  logic              wr_en_q, wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic [7:0]        wr_data_q, wr_data_nxt;
  logic              in_ready_q, in_ready_nxt;
  logic              busy_q, busy_nxt;

  // Where the cursor lands on a newline, shared by LF and end-of-row wrap.
  logic              row_wrap;
  logic [5:0]        nl_row;
  logic [ADDR_W-1:0] nl_base;

  assign row_wrap = (row == ROW_LAST);
  assign nl_row   = row_wrap ? 6'd0 : row + 6'd1;
  assign nl_base  = row_wrap ? '0 : row_base + ROW_STEP;

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.in_ready = in_ready_q;
  assign cur_col      = col;
  assign cur_row      = row;
  assign busy         = busy_q;

  // State and registered outputs; reset restarts the full-screen clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR_ALL;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      clr_cnt    <= '0;
      line_cnt   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      row_base   <= row_base_nxt;
      clr_cnt    <= clr_cnt_nxt;
      line_cnt   <= line_cnt_nxt;
      wr_en_q    <= wr_en_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_data_q  <= wr_data_nxt;
      in_ready_q <= in_ready_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // Next-state, cursor and write-port decisions for the coming cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    row_base_nxt = row_base;
    clr_cnt_nxt  = clr_cnt;
    line_cnt_nxt = line_cnt;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr_q;
    wr_data_nxt  = wr_data_q;
    in_ready_nxt = 1'b0;
    busy_nxt     = 1'b1;

    case (state)
      CLEAR_ALL: begin
        if (clr_cnt == CLR_END) begin
          // Trailing cycle after the last write: home the cursor, open input.
          state_nxt    = IDLE;
          col_nxt      = '0;
          row_nxt      = '0;
          row_base_nxt = '0;
          in_ready_nxt = 1'b1;
          busy_nxt     = 1'b0;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = clr_cnt[ADDR_W-1:0];
          wr_data_nxt = CH_SPACE;
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end

      CLEAR_LINE: begin
        if (line_cnt == LINE_END) begin
          state_nxt    = IDLE;
          in_ready_nxt = 1'b1;
          busy_nxt     = 1'b0;
        end else begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = row_base + ADDR_W'(line_cnt);
          wr_data_nxt  = CH_SPACE;
          line_cnt_nxt = line_cnt + 8'd1;
        end
      end

      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
        if (bus.in_valid && in_ready_q) begin
          case (bus.in_data)
            CH_CR: col_nxt = '0;

            CH_LF: begin
              // LF has no glyph write, so the first blanking write is
              // issued right away and the row clear starts at cell 1.
              col_nxt      = '0;
              row_nxt      = nl_row;
              row_base_nxt = nl_base;
              wr_en_nxt    = 1'b1;
              wr_addr_nxt  = nl_base;
              wr_data_nxt  = CH_SPACE;
              line_cnt_nxt = 8'd1;
              state_nxt    = CLEAR_LINE;
              in_ready_nxt = 1'b0;
              busy_nxt     = 1'b1;
            end

            CH_BS: begin
              if (col != 7'd0) begin
                col_nxt     = col - 7'd1;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = row_base + ADDR_W'(col - 7'd1);
                wr_data_nxt = CH_SPACE;
              end
            end

            CH_FF: begin
              state_nxt    = CLEAR_ALL;
              clr_cnt_nxt  = '0;
              in_ready_nxt = 1'b0;
              busy_nxt     = 1'b1;
            end

            default: begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = row_base + ADDR_W'(col);
              wr_data_nxt = bus.in_data;
              if (col == COL_LAST) begin
                // The glyph write occupies this slot; the row clear follows.
                col_nxt      = '0;
                row_nxt      = nl_row;
                row_base_nxt = nl_base;
                line_cnt_nxt = 8'd0;
                state_nxt    = CLEAR_LINE;
                in_ready_nxt = 1'b0;
                busy_nxt     = 1'b1;
              end else begin
                col_nxt = col + 7'd1;
              end
            end
          endcase
        end
      end

      default: begin
        state_nxt   = CLEAR_ALL;
        clr_cnt_nxt = '0;
      end
    endcase
  end

endmodule
